// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================================
// audio_pkg : shared widths, waveform encodings and full-scale constants
// Rev 1.0
// ============================================================================
package audio_pkg;

  localparam int PHASE_W_DEF  = 32;
  localparam int SAMPLE_W_DEF = 24;

  typedef enum logic [1:0] {
    WAVE_SAW    = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SILENT = 2'd3
  } wave_e;

  // Square wave is kept symmetric, so the negative rail is 0x800001, not 0x800000
  localparam logic [SAMPLE_W_DEF-1:0] FS_POS = 24'h7FFFFF;
  localparam logic [SAMPLE_W_DEF-1:0] FS_NEG = 24'h800001;

endpackage
`default_nettype wire

// File: rtl/audio_tick_gen.sv
`default_nettype none
// ============================================================================
// audio_tick_gen : sample-rate divider, one-cycle sample_tick every DIV clocks
// Rev 1.0
// ============================================================================
module audio_tick_gen #(
  parameter int SYS_CLK_FREQ = 50_000_000,
  parameter int SAMPLE_RATE  = 48_000
) (
  input  logic sys_clk,
  input  logic reset,
  output logic sample_tick
);

  localparam int DIV   = SYS_CLK_FREQ / SAMPLE_RATE;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick_q, tick_d;

  // Tick is registered from the next count so it is high in the cycle where div_cnt == DIV-1
  always_comb begin
    div_cnt_d = (div_cnt_q == C_LAST) ? '0 : div_cnt_q + CNT_W'(1);
    tick_d    = (div_cnt_d == C_LAST);
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
    end
  end

  assign sample_tick = tick_q;

endmodule
`default_nettype wire

// File: rtl/audio_tone_gen.sv
`default_nettype none
// ============================================================================
// audio_tone_gen : phase-accumulator tone synthesiser with valid/ready output
// Rev 1.0
// ============================================================================
module audio_tone_gen
  import audio_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 50_000_000,
  parameter int SAMPLE_RATE  = 48_000,
  parameter int PHASE_W      = PHASE_W_DEF,
  parameter int SAMPLE_W     = SAMPLE_W_DEF
) (
  input  logic                sys_clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PHASE_W-1:0]  freq_word,
  input  logic [1:0]          wave_sel,
  input  logic [3:0]          volume,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic                sample_tick,
  output logic                overrun
);

  localparam logic [SAMPLE_W-1:0] C_MSB    = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [SAMPLE_W-1:0] C_FS_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [SAMPLE_W-1:0] C_FS_NEG = {1'b1, {(SAMPLE_W-2){1'b0}}, 1'b1};

  logic tick;

  audio_tick_gen #(
    .SYS_CLK_FREQ (SYS_CLK_FREQ),
    .SAMPLE_RATE  (SAMPLE_RATE)
  ) u_tick (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .sample_tick (tick)
  );

  // Stage 0: accumulator plus the controls captured with it
  logic [PHASE_W-1:0]  phase_q, phase_d;
  wave_e               s0_sel_q;
  logic [3:0]          s0_vol_q;
  logic                s0_en_q, s0_vld_q;
  // Stage 1: raw waveform
  logic signed [SAMPLE_W-1:0] wave_q, wave_d;
  logic [3:0]                 s1_vol_q;
  logic                       s1_vld_q;
  // Stage 2: attenuated sample
  logic signed [SAMPLE_W-1:0] att_q, att_d;
  logic                       s2_vld_q;
  // Output register
  logic [SAMPLE_W-1:0] out_q, out_d;
  logic                valid_q, valid_d;
  logic                overrun_q, overrun_d;

  logic [SAMPLE_W-1:0] u;
  logic [SAMPLE_W-2:0] tri_t;
  logic                load;

  always_comb begin
    phase_d = enable ? phase_q + freq_word : '0;

    u      = phase_q[PHASE_W-1 -: SAMPLE_W];
    tri_t  = u[SAMPLE_W-1] ? ~u[SAMPLE_W-2:0] : u[SAMPLE_W-2:0];
    wave_d = '0;
    if (s0_en_q) begin
      case (s0_sel_q)
        WAVE_SAW:    wave_d = u ^ C_MSB;
        WAVE_SQUARE: wave_d = phase_q[PHASE_W-1] ? C_FS_NEG : C_FS_POS;
        WAVE_TRI:    wave_d = {tri_t, 1'b0} ^ C_MSB;
        default:     wave_d = '0;
      endcase
    end

    att_d = wave_q >>> s1_vol_q;

    // A fresh sample always wins; overwriting an undelivered one is flagged
    load      = s2_vld_q;
    out_d     = load ? att_q : out_q;
    valid_d   = load | (valid_q & ~sample_ready);
    overrun_d = overrun_q | (load & valid_q & ~sample_ready);
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      phase_q   <= '0;
      s0_sel_q  <= WAVE_SAW;
      s0_vol_q  <= '0;
      s0_en_q   <= 1'b0;
      s0_vld_q  <= 1'b0;
      wave_q    <= '0;
      s1_vol_q  <= '0;
      s1_vld_q  <= 1'b0;
      att_q     <= '0;
      s2_vld_q  <= 1'b0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      s0_vld_q <= tick;
      if (tick) begin
        phase_q  <= phase_d;
        s0_sel_q <= wave_e'(wave_sel);
        s0_vol_q <= volume;
        s0_en_q  <= enable;
      end
      s1_vld_q <= s0_vld_q;
      if (s0_vld_q) begin
        wave_q   <= wave_d;
        s1_vol_q <= s0_vol_q;
      end
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        att_q <= att_d;
      end
      out_q     <= out_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign sample_out   = out_q;
  assign sample_valid = valid_q;
  assign sample_tick  = tick;
  assign overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_tone_gen.sv
`default_nettype none
// ============================================================================
// tb_audio_tone_gen : scoreboard bench for audio_tone_gen
// Rev 1.0
// ============================================================================
module tb_audio_tone_gen;

  localparam int DIV = 50_000_000 / 48_000;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [31:0] freq_word;
  logic [1:0]  wave_sel;
  logic [3:0]  volume;
  logic [23:0] sample_out;
  logic        sample_valid;
  logic        sample_ready;
  logic        sample_tick;
  logic        overrun;

  audio_tone_gen dut (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .enable       (enable),
    .freq_word    (freq_word),
    .wave_sel     (wave_sel),
    .volume       (volume),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_tick  (sample_tick),
    .overrun      (overrun)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  int rel_cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  logic [23:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int v);
    logic [31:0] w;
    w = v;
    exp_q.push_back(w[23:0]);
  endtask

  // Monitor: every accepted transfer is matched against the next expected sample
  always @(negedge sys_clk) begin
    if (!reset && sample_valid && sample_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_sample: got %0h, expected no transfer", sample_out);
      end else begin
        check("sample", {8'h0, sample_out}, {8'h0, exp_q.pop_front()});
      end
    end
  end

  // Returns at the falling edge inside the tick cycle; t = rising edges since reset release
  task automatic wait_tick(output int t);
    int k;
    k = 0;
    do begin
      @(negedge sys_clk);
      k++;
    end while (!sample_tick && k < 2 * DIV);
    if (!sample_tick) begin
      n_checks++;
      n_fail++;
      $display("FAIL tick_timeout: got no tick, expected one within %0d cycles", 2 * DIV);
    end
    t = cyc - rel_cyc;
  endtask

  task automatic go(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  int t, prev_t, k;

  initial begin
    reset        = 1'b1;
    enable       = 1'b1;
    freq_word    = 32'h1000_0000;
    wave_sel     = 2'd0;
    volume       = 4'd0;
    sample_ready = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("reset_out",     {8'h0, sample_out}, 32'h0);
    check("reset_valid",   {31'h0, sample_valid}, 32'h0);
    check("reset_tick",    {31'h0, sample_tick}, 32'h0);
    check("reset_overrun", {31'h0, overrun}, 32'h0);
    reset   = 1'b0;
    rel_cyc = cyc;

    // Saw ramp, 16-sample period, wrapping to full negative on the 16th
    prev_t = 0;
    for (int i = 1; i <= 17; i++) begin
      wait_tick(t);
      push(-8388608 + (i % 16) * 1048576);
      if (i == 1) begin
        check("first_tick_cycle", t, DIV - 1);
        for (int j = 1; j <= 4; j++) begin
          @(negedge sys_clk);
          check("valid_latency", {31'h0, sample_valid}, (j == 4) ? 32'h1 : 32'h0);
        end
      end else begin
        check("tick_spacing", t - prev_t, DIV);
      end
      prev_t = t;
      go(8);
    end

    // Square at volume 4, phase alternating MSB
    wave_sel  = 2'd1;
    volume    = 4'd4;
    freq_word = 32'h8000_0000;
    for (int i = 0; i < 3; i++) begin
      wait_tick(t);
      push((i % 2 == 0) ? 32'h00F8_0000 : 32'h0007_FFFF);
      go(8);
    end

    // Stall across two ticks: second sample overwrites the first
    volume       = 4'd0;
    sample_ready = 1'b0;
    wait_tick(t);
    go(8);
    @(negedge sys_clk);
    check("stall_first_out",     {8'h0, sample_out}, 32'h007F_FFFF);
    check("stall_first_overrun", {31'h0, overrun}, 32'h0);
    wait_tick(t);
    push(32'h0080_0001);
    go(8);
    @(negedge sys_clk);
    check("overrun_set",     {31'h0, overrun}, 32'h1);
    check("overrun_out",     {8'h0, sample_out}, 32'h0080_0001);
    check("overrun_valid",   {31'h0, sample_valid}, 32'h1);
    go(1);
    sample_ready = 1'b1;
    go(1);
    sample_ready = 1'b0;
    @(negedge sys_clk);
    check("valid_drop", {31'h0, sample_valid}, 32'h0);
    sample_ready = 1'b1;

    // Disable forces zero output and restarts phase
    wave_sel  = 2'd0;
    freq_word = 32'h1000_0000;
    enable    = 1'b0;
    wait_tick(t);
    push(0);
    go(8);
    enable = 1'b1;
    wait_tick(t);
    push(-7340032);
    go(8);
    wait_tick(t);
    push(-6291456);
    go(8);
    check("overrun_sticky", {31'h0, overrun}, 32'h1);

    // Triangle at volume 1 from phase 0x2000_0000, then a fold-over point, then silence
    wave_sel = 2'd2;
    volume   = 4'd1;
    for (int i = 0; i < 3; i++) begin
      wait_tick(t);
      push((i == 0) ? 32'h00F0_0000 : (i == 1) ? 32'h0 : 32'h0010_0000);
      go(8);
    end
    freq_word = 32'h4000_0000;
    wait_tick(t);
    push(32'h002F_FFFF);
    go(8);
    wave_sel = 2'd3;
    wait_tick(t);
    push(0);
    go(8);

    // Reset while a sample is pending
    wave_sel     = 2'd0;
    volume       = 4'd0;
    freq_word    = 32'h1000_0000;
    sample_ready = 1'b0;
    wait_tick(t);
    repeat (5) @(negedge sys_clk);
    check("pending_valid", {31'h0, sample_valid}, 32'h1);
    reset = 1'b1;
    #1;
    check("mid_reset_valid",   {31'h0, sample_valid}, 32'h0);
    check("mid_reset_out",     {8'h0, sample_out}, 32'h0);
    check("mid_reset_overrun", {31'h0, overrun}, 32'h0);
    repeat (2) @(negedge sys_clk);
    sample_ready = 1'b1;
    reset        = 1'b0;
    rel_cyc      = cyc;
    wait_tick(t);
    check("post_reset_tick", t, DIV - 1);
    push(-7340032);
    k = 0;
    while (!sample_valid && k < 10) begin
      @(negedge sys_clk);
      k++;
    end
    check("post_reset_valid_cycle", cyc - rel_cyc, DIV + 3);
    go(8);
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
